// File: rtl/bf_pc_sequencer_if.sv
// Sequencer-facing bus: program-memory address/data plus the op handshake
// to the datapath and the datapath's zero flag.
interface bf_pc_sequencer_if #(
  parameter int PC_W = 9
) ();
  logic [PC_W-1:0] pc;
  logic [7:0]      instr;
  logic            cell_zero;
  logic            op_valid;
  logic [2:0]      op_code;
  logic            op_ready;

  modport master (
    output pc, op_valid, op_code,
    input  instr, cell_zero, op_ready
  );

  modport slave (
    input  pc, op_valid, op_code,
    output instr, cell_zero, op_ready
  );
endinterface

// File: rtl/bf_pc_sequencer.sv
// Brainfuck program-counter sequencer: fetches program bytes, issues datapath
// ops with a valid/ready handshake and resolves '[' / ']' by bracket scanning.
module bf_pc_sequencer #(
  parameter int PC_W    = 9,
  parameter int DEPTH_W = 8
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  bf_pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_SCAN_FWD, S_SCAN_BWD, S_HALT, S_ERROR
  } state_t;

  localparam logic [7:0] B_NUL = 8'h00;
  localparam logic [7:0] B_OPEN = 8'h5B;
  localparam logic [7:0] B_CLOSE = 8'h5D;
  localparam logic [PC_W-1:0] PC_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [2:0]          op_code_q, op_code_d;
  logic                op_valid_q;

  // {is_op, op_code} for the six datapath bytes.
  function automatic logic [3:0] decode_op(input logic [7:0] b);
    case (b)
      8'h2B:   return {1'b1, 3'd0};
      8'h2D:   return {1'b1, 3'd1};
      8'h3E:   return {1'b1, 3'd2};
      8'h3C:   return {1'b1, 3'd3};
      8'h2E:   return {1'b1, 3'd4};
      8'h2C:   return {1'b1, 3'd5};
      default: return 4'b0000;
    endcase
  endfunction

  logic [3:0] dec;
  assign dec = decode_op(bus.instr);

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    depth_d   = depth_q;
    op_code_d = op_code_q;

    unique case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          depth_d = '0;
        end
      end

      S_FETCH: begin
        if (bus.instr == B_NUL) begin
          state_d = S_HALT;
        end else if (dec[3]) begin
          state_d   = S_ISSUE;
          op_code_d = dec[2:0];
        end else if (bus.instr == B_CLOSE && !bus.cell_zero) begin
          // Backward jump: step onto the byte before ']' and scan for '['.
          if (pc_q == '0) state_d = S_ERROR;
          else begin
            pc_d    = pc_q - PC_W'(1);
            depth_d = DEPTH_ONE;
            state_d = S_SCAN_BWD;
          end
        end else if (pc_q == PC_MAX) begin
          state_d = S_ERROR;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (bus.instr == B_OPEN && bus.cell_zero) begin
            depth_d = DEPTH_ONE;
            state_d = S_SCAN_FWD;
          end
        end
      end

      S_ISSUE: begin
        if (bus.op_ready) begin
          if (pc_q == PC_MAX) state_d = S_ERROR;
          else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_SCAN_FWD: begin
        // Every non-NUL byte advances pc, so the pc limit is checked up front.
        if (bus.instr == B_NUL || pc_q == PC_MAX) begin
          state_d = S_ERROR;
        end else if (bus.instr == B_OPEN) begin
          if (depth_q == DEPTH_MAX) state_d = S_ERROR;
          else begin
            depth_d = depth_q + DEPTH_W'(1);
            pc_d    = pc_q + PC_W'(1);
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (bus.instr == B_CLOSE) begin
            if (depth_q == DEPTH_ONE) state_d = S_FETCH;
            else depth_d = depth_q - DEPTH_W'(1);
          end
        end
      end

      S_SCAN_BWD: begin
        if (bus.instr == B_OPEN && depth_q == DEPTH_ONE) begin
          if (pc_q == PC_MAX) state_d = S_ERROR;
          else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end else if (pc_q == '0) begin
          state_d = S_ERROR;
        end else if (bus.instr == B_CLOSE) begin
          if (depth_q == DEPTH_MAX) state_d = S_ERROR;
          else begin
            depth_d = depth_q + DEPTH_W'(1);
            pc_d    = pc_q - PC_W'(1);
          end
        end else begin
          pc_d = pc_q - PC_W'(1);
          if (bus.instr == B_OPEN) depth_d = depth_q - DEPTH_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      depth_q    <= '0;
      op_code_q  <= '0;
      op_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      depth_q    <= depth_d;
      op_code_q  <= op_code_d;
      op_valid_q <= (state_d == S_ISSUE);
      busy       <= (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                    (state_d == S_SCAN_FWD) || (state_d == S_SCAN_BWD);
      done       <= (state_d == S_HALT);
      err        <= (state_d == S_ERROR);
    end
  end

  assign bus.pc       = pc_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_code  = op_code_q;

endmodule

// File: doc/bf_pc_sequencer.md
BF_PC_SEQUENCER -- requirements
Module: bf_pc_sequencer

Interface
REQ-001 Parameter PC_W, default 9: program-counter width.
REQ-002 Parameter DEPTH_W, default 8: bracket-nesting counter width.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
REQ-005 start  input  1  begin execution at pc=0; honoured only in IDLE, HALT and ERROR.
REQ-006 instr  input  8  program byte at address pc; combinational memory read, valid in the same cycle.
REQ-007 cell_zero  input  1  current data cell == 0; valid from the cycle after the last op_ready handshake.
REQ-008 op_ready  input  1  datapath accepts the issued op.
REQ-009 pc  output  PC_W  program counter, drives program-memory address.
REQ-010 op_valid  output  1  datapath op offered.
REQ-011 op_code  output  3  0=INC '+'(0x2B), 1=DEC '-'(0x2D), 2=RIGHT '>'(0x3E), 3=LEFT '<'(0x3C), 4=OUT '.'(0x2E), 5=IN ','(0x2C).
REQ-012 busy  output  1  high in FETCH, ISSUE, SCAN_FWD, SCAN_BWD.
REQ-013 done  output  1  high in HALT.
REQ-014 err  output  1  high in ERROR.

Function
REQ-015 States IDLE, FETCH, ISSUE, SCAN_FWD, SCAN_BWD, HALT, ERROR; all outputs registered.
REQ-016 IDLE/HALT/ERROR + start=1 -> pc<=0, depth<=0, FETCH next cycle; start ignored in all other states.
REQ-017 FETCH, instr=0x00 -> HALT, pc unchanged.
REQ-018 FETCH, instr is one of the six op bytes -> ISSUE, op_code latched, op_valid=1 from next cycle, pc unchanged.
REQ-019 FETCH, '[' (0x5B): cell_zero=1 -> depth<=1, pc<=pc+1, SCAN_FWD; cell_zero=0 -> pc<=pc+1, stay FETCH.
REQ-020 FETCH, ']' (0x5D): cell_zero=0 -> depth<=1, pc<=pc-1, SCAN_BWD; cell_zero=1 -> pc<=pc+1, stay FETCH.
REQ-021 FETCH, any other byte -> comment; pc<=pc+1, stay FETCH (one cycle per byte).
REQ-022 ISSUE: op_valid and op_code held stable while op_ready=0; pc frozen.
REQ-023 ISSUE, op_ready=1 -> op_valid<=0, pc<=pc+1, FETCH; an op therefore costs a minimum of 2 cycles.
REQ-024 SCAN_FWD, one byte per cycle: '[' -> depth+1, pc+1; ']' with depth=1 -> pc+1, FETCH (lands after matching ']'); ']' with depth>1 -> depth-1, pc+1; other -> pc+1.
REQ-025 SCAN_BWD, one byte per cycle: ']' -> depth+1, pc-1; '[' with depth=1 -> pc+1, FETCH (lands after matching '['); '[' with depth>1 -> depth-1, pc-1; other -> pc-1.
REQ-026 SCAN_FWD hitting 0x00, or pc=2^PC_W-1 needing increment -> ERROR, pc held.
REQ-027 SCAN_BWD with pc=0 needing decrement -> ERROR, pc held.
REQ-028 depth=2^DEPTH_W-1 needing increment -> ERROR.
REQ-029 FETCH incrementing pc past 2^PC_W-1 -> ERROR; pc never wraps.
REQ-030 op_valid=1 only in ISSUE; op_code otherwise holds its last value.

Reset
REQ-031 rst=0 at any edge, in any state, including mid-ISSUE or mid-scan -> next cycle: IDLE, pc=0, depth=0, op_valid=0, op_code=0, busy=0, done=0, err=0.
REQ-032 While rst=0, start is ignored; the first start is accepted on the cycle after rst returns to 1.

Verification
REQ-033 Program "++." then 0x00, op_ready=1 -> op_code 0,0,4 issued in order, each handshaken once; done=1, pc=3.
REQ-034 Program "[+]" then 0x00, cell_zero=1 -> no op_valid; scan exits to pc=3; done=1 with pc=3.
REQ-035 Program "+[-]" then 0x00; cell_zero=0 until second DEC handshake, then 1 -> ops 0,1,1; SCAN_BWD returns pc=2 once; done=1, pc=4.
REQ-036 Program "[[]" then 0x00, cell_zero=1 -> SCAN_FWD reaches 0x00 at pc=3; err=1, busy=0, pc=3.
REQ-037 Program "+", op_ready=0 for 5 cycles -> op_valid=1, op_code=0, pc=0 stable throughout; handshake on cycle 6 -> pc=1.
REQ-038 rst=0 asserted during ISSUE -> next cycle op_valid=0, pc=0, state IDLE; start then reruns from pc=0.
